flappy_frame_sequencer: RTL and testbench
=========================================

// Module: flappy_frame_sequencer
// PURPOSE
// - Per-frame game controller: on each Frame_Tick it steps physics, steps pipe scroll, then scans all pipes for collision/score.
// - Owns the game FSM (INIT/PLAY/LOSE) with Start/Ack handshakes and a 4-digit BCD score for the SSD.
// - Sits between the pipe X RAM + gap Y ROM (reads them by index), flight physics (receives Phys_Step, returns Bird_Y) and vga/SSD.
// PARAMETERS
// - NUM_PIPES  4    pipes scanned per frame; index width IW = clog2(NUM_PIPES), min 1
// - BIRD_X     200  fixed bird left edge, pixels
// - BIRD_W     16   bird width/height, pixels
// - PIPE_W     40   pipe width, pixels
// - GAP_H      120  vertical gap height, pixels
// - FLOOR_Y    464  Bird_Y >= FLOOR_Y is a floor hit
// PORTS
// - Clk          in   1   system clock
// - Reset_n      in   1   asynchronous, active-low reset
// - Start        in   1   leave INIT (level, sampled per cycle)
// - Ack          in   1   leave LOSE (level, sampled per cycle)
// - Frame_Tick   in   1   1-cycle frame strobe
// - Bird_Y       in   10  bird top edge from physics, stable outside Phys_Step cycle
// - Pipe_X       in   10  pipe left edge, valid 1 cycle after Pipe_Index
// - Pipe_Gap_Y   in   10  gap top edge, valid 1 cycle after Pipe_Index
// - Pipe_Index   out  IW  pipe being read
// - Phys_Step    out  1   1-cycle pulse: physics advance
// - Scroll_Step  out  1   1-cycle pulse: pipe RAM scroll advance
// - Busy         out  1   frame sequence in progress
// - Overrun      out  1   1-cycle pulse: Frame_Tick dropped
// - q_Initial, q_Play, q_Lose  out 1 each  one-hot game state
// - Score_BCD    out  16  4 BCD digits, [15:12] thousands
// BEHAVIOUR
// - Reset: INIT; q_Initial=1, others 0; Score_BCD=0; Pipe_Index=0; all pulses/Busy 0; passed bitmap=0; pending=0.
// - INIT: Start -> PLAY next cycle, clear score and passed bitmap. Frame_Tick ignored.
// - PLAY sub-sequence on Frame_Tick (or pending) while idle: cycle0 PHYS (Phys_Step=1), cycle1 SCROLL (Scroll_Step=1),
//   cycle2 floor check, then SCAN: Pipe_Index=0..NUM_PIPES-1 one per cycle, compare data one cycle later;
//   last compare NUM_PIPES+3 cycles after tick, then DONE (1 cycle) -> idle. Busy=1 from PHYS through DONE.
// - Collision for pipe i: horizontal overlap (Pipe_X < BIRD_X+BIRD_W) && (Pipe_X+PIPE_W > BIRD_X) AND
//   (Bird_Y < Pipe_Gap_Y || Bird_Y+BIRD_W > Pipe_Gap_Y+GAP_H). Floor: Bird_Y >= FLOOR_Y.
// - All sums in 11 bits (no wrap). Any hit latched; at DONE a hit -> LOSE; the rest of the scan still completes.
// - Score: Pipe_X+PIPE_W <= BIRD_X and passed[i]==0 -> BCD +1, passed[i]=1; Pipe_X > BIRD_X+BIRD_W clears passed[i] (wrap/respawn).
//   BCD increment with carry per digit; saturates at 9999.
// - Frame_Tick while Busy: set pending (one-deep); tick while pending already set -> Overrun pulse, tick dropped.
//   Pending served the cycle after DONE.
// - LOSE: freeze score, no pulses, pending cleared; Ack -> INIT next cycle (score held until Start).
// - Start and Ack both high: only the one relevant to current state is honoured.
// - Reset mid-sequence: immediate return to reset values; no pulse completes.
// CONFIGURATION
// - INVINCIBLE_EN defined: collisions/floor hits never enter LOSE; extra output Hit_Cnt (8 bits) increments once per frame
//   with any hit, saturating at 255, cleared on Start. Undefined: behaviour as above, no Hit_Cnt port.
// TESTING
// - Reset low mid-SCAN -> q_Initial=1, Score_BCD=0, Busy=0 while reset asserted.
// - INIT, Start=1 one cycle -> q_Play=1 next cycle; Frame_Tick -> Phys_Step at +1, Scroll_Step at +2, Busy low at +NUM_PIPES+5.
// - Pipe0 X=100 (passed), others X=600, Bird_Y=200 -> Score_BCD 0x0001 after one frame, still 0x0001 next frame.
// - Pipe1 X=190 gap_Y=300, Bird_Y=200 -> q_Lose=1 after DONE; Ack -> q_Initial=1, score held.
// - Bird_Y=464, no pipes overlapping -> LOSE; Bird_Y=463 -> stays PLAY.
// - Three Frame_Ticks within one busy sequence -> one pending frame runs, Overrun pulses once.
// - Score preset via 9999 passes -> stays 0x9999; INVINCIBLE_EN with collision -> q_Play stays 1, Hit_Cnt=1.

Source files
------------

// File: rtl/flappy_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its neighbours: game control
// handshakes, physics step/bird height, pipe RAM/ROM read port, VGA/SSD status.
// INVINCIBLE_EN adds the Hit_Cnt status signal.
interface flappy_frame_sequencer_if #(
  parameter int NUM_PIPES = 4
);
  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic          Start;
  logic          Ack;
  logic          Frame_Tick;
  logic [9:0]    Bird_Y;
  logic [9:0]    Pipe_X;
  logic [9:0]    Pipe_Gap_Y;
  logic [IW-1:0] Pipe_Index;
  logic          Phys_Step;
  logic          Scroll_Step;
  logic          Busy;
  logic          Overrun;
  logic          q_Initial;
  logic          q_Play;
  logic          q_Lose;
  logic [15:0]   Score_BCD;
`ifdef INVINCIBLE_EN
  logic [7:0]    Hit_Cnt;

  modport master (
    input  Start, Ack, Frame_Tick, Bird_Y, Pipe_X, Pipe_Gap_Y,
    output Pipe_Index, Phys_Step, Scroll_Step, Busy, Overrun,
           q_Initial, q_Play, q_Lose, Score_BCD, Hit_Cnt
  );
  modport slave (
    output Start, Ack, Frame_Tick, Bird_Y, Pipe_X, Pipe_Gap_Y,
    input  Pipe_Index, Phys_Step, Scroll_Step, Busy, Overrun,
           q_Initial, q_Play, q_Lose, Score_BCD, Hit_Cnt
  );
`else
  modport master (
    input  Start, Ack, Frame_Tick, Bird_Y, Pipe_X, Pipe_Gap_Y,
    output Pipe_Index, Phys_Step, Scroll_Step, Busy, Overrun,
           q_Initial, q_Play, q_Lose, Score_BCD
  );
  modport slave (
    output Start, Ack, Frame_Tick, Bird_Y, Pipe_X, Pipe_Gap_Y,
    input  Pipe_Index, Phys_Step, Scroll_Step, Busy, Overrun,
           q_Initial, q_Play, q_Lose, Score_BCD
  );
`endif
endinterface

// File: rtl/flappy_frame_sequencer.sv
// Per-frame game controller: INIT/PLAY/LOSE game FSM, per-frame sequence
// PHYS -> SCROLL -> FLOOR -> SCAN(NUM_PIPES) -> DONE, collision and score.
// Optional macro INVINCIBLE_EN: hits never lose the game, Hit_Cnt counts hit frames.
module flappy_frame_sequencer #(
  parameter int NUM_PIPES = 4,
  parameter int BIRD_X    = 200,
  parameter int BIRD_W    = 16,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int FLOOR_Y   = 464
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  flappy_frame_sequencer_if.master        bus
);
  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_PIPES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PHYS, S_SCROLL, S_FLOOR, S_SCAN, S_DONE, S_LOSE
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          scan_cnt;
  logic [NUM_PIPES-1:0]   passed;
  logic [15:0]            score;
  logic                   pending;
  logic                   overrun;
  logic                   hit;
  logic                   busy;
  logic                   lose_now;
`ifdef INVINCIBLE_EN
  logic [7:0]             hit_cnt;
`endif

  // BCD +1 with per-digit carry, saturating at 9999
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (r[4*d +: 4] == 4'd9) begin
            r[4*d +: 4] = 4'd0;
          end else begin
            r[4*d +: 4] = r[4*d +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Geometry, all in 11 bits so no sum can wrap
  logic [10:0] px, by, gy;
  logic        pipe_hit, pipe_pass, pipe_clear, floor_hit;
  assign px         = {1'b0, bus.Pipe_X};
  assign by         = {1'b0, bus.Bird_Y};
  assign gy         = {1'b0, bus.Pipe_Gap_Y};
  assign pipe_hit   = (px < 11'(BIRD_X + BIRD_W)) && ((px + 11'(PIPE_W)) > 11'(BIRD_X)) &&
                      ((by < gy) || ((by + 11'(BIRD_W)) > (gy + 11'(GAP_H))));
  assign pipe_pass  = (px + 11'(PIPE_W)) <= 11'(BIRD_X);
  assign pipe_clear = px > 11'(BIRD_X + BIRD_W);
  assign floor_hit  = by >= 11'(FLOOR_Y);

  assign busy = (state == S_PHYS) || (state == S_SCROLL) || (state == S_FLOOR) ||
                (state == S_SCAN) || (state == S_DONE);
`ifdef INVINCIBLE_EN
  assign lose_now = 1'b0;
`else
  assign lose_now = hit;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  // Next-state selection and strobe outputs
  always_comb begin
    state_nxt       = state;
    bus.Phys_Step   = 1'b0;
    bus.Scroll_Step = 1'b0;
    bus.Pipe_Index  = '0;
    case (state)
      S_INIT:   if (bus.Start) state_nxt = S_IDLE;
      S_IDLE:   if (bus.Frame_Tick || pending) state_nxt = S_PHYS;
      S_PHYS: begin
        bus.Phys_Step = 1'b1;
        state_nxt     = S_SCROLL;
      end
      S_SCROLL: begin
        bus.Scroll_Step = 1'b1;
        state_nxt       = S_FLOOR;
      end
      S_FLOOR:  state_nxt = S_SCAN;
      S_SCAN: begin
        if (scan_cnt == LAST) state_nxt = S_DONE;
        else                  bus.Pipe_Index = scan_cnt + IW'(1);
      end
      S_DONE: begin
        if (lose_now)     state_nxt = S_LOSE;
        else if (pending) state_nxt = S_PHYS;
        else              state_nxt = S_IDLE;
      end
      S_LOSE:   if (bus.Ack) state_nxt = S_INIT;
      default:  state_nxt = S_INIT;
    endcase
  end

  // Scan counter, hit latch, pending/overrun tracking and score
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scan_cnt <= '0;
      passed   <= '0;
      score    <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      hit      <= 1'b0;
`ifdef INVINCIBLE_EN
      hit_cnt  <= '0;
`endif
    end else begin
      overrun  <= 1'b0;
      scan_cnt <= (state == S_SCAN) ? scan_cnt + IW'(1) : '0;

      if (state == S_PHYS)                hit <= 1'b0;
      else if (state == S_FLOOR && floor_hit) hit <= 1'b1;
      else if (state == S_SCAN && pipe_hit)   hit <= 1'b1;

      if (state == S_INIT || state == S_LOSE) begin
        pending <= 1'b0;
      end else if (state == S_IDLE) begin
        // a fresh tick arriving alongside a pending one keeps one queued
        pending <= pending && bus.Frame_Tick;
      end else if (state == S_DONE && lose_now) begin
        pending <= 1'b0;
      end else if (state == S_DONE && pending) begin
        pending <= bus.Frame_Tick;
      end else if (bus.Frame_Tick) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      if (state == S_INIT && bus.Start) begin
        score  <= '0;
        passed <= '0;
      end else if (state == S_SCAN) begin
        if (pipe_pass && !passed[scan_cnt]) begin
          score            <= bcd_inc(score);
          passed[scan_cnt] <= 1'b1;
        end else if (pipe_clear) begin
          passed[scan_cnt] <= 1'b0;
        end
      end

`ifdef INVINCIBLE_EN
      if (state == S_INIT && bus.Start)         hit_cnt <= '0;
      else if (state == S_DONE && hit && hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
`endif
    end
  end

  assign bus.Busy      = busy;
  assign bus.Overrun   = overrun;
  assign bus.q_Initial = (state == S_INIT);
  assign bus.q_Lose    = (state == S_LOSE);
  assign bus.q_Play    = !((state == S_INIT) || (state == S_LOSE));
  assign bus.Score_BCD = score;
`ifdef INVINCIBLE_EN
  assign bus.Hit_Cnt   = hit_cnt;
`endif
endmodule

// File: tb/tb_flappy_frame_sequencer.sv
// Self-checking bench for flappy_frame_sequencer: frame vector table with a
// scoreboard, plus hand sequences for timing, overrun, saturation and reset.
module tb_flappy_frame_sequencer;
  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  flappy_frame_sequencer_if #(.NUM_PIPES(4)) bus ();
  flappy_frame_sequencer #(.NUM_PIPES(4)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

`ifdef INVINCIBLE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Pipe RAM / gap ROM model: registered read, one cycle after Pipe_Index
  logic [9:0] px_mem [4];
  logic [9:0] gy_mem [4];
  bit         sat_mode = 1'b0;
  bit         parity;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      parity     <= 1'b0;
      bus.Pipe_X <= 10'd0;
      bus.Pipe_Gap_Y <= 10'd0;
    end else begin
      if (bus.Phys_Step) parity <= ~parity;
      bus.Pipe_X     <= sat_mode ? (parity ? 10'd100 : 10'd600) : px_mem[bus.Pipe_Index];
      bus.Pipe_Gap_Y <= gy_mem[bus.Pipe_Index];
    end
  end

  typedef struct {
    logic [3:0][9:0] x;
    logic [9:0]      g1;
    logic [9:0]      y;
    int              passes;
    bit              hit;
  } vec_t;

  typedef struct {
    logic [15:0] score;
    bit          lose;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];

  function automatic vec_t mk(input int x0, x1, x2, x3, g1, y, passes, input bit hit);
    vec_t v;
    v.x      = {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
    v.g1     = 10'(g1);
    v.y      = 10'(y);
    v.passes = passes;
    v.hit    = hit;
    return v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!bus.Busy) break;
      step();
    end
    check("frame_done_timeout", {31'd0, bus.Busy}, 32'd0);
  endtask

  task automatic set_pipes(input logic [3:0][9:0] x, input logic [9:0] g1);
    for (int p = 0; p < 4; p++) begin
      px_mem[p] = x[p];
      gy_mem[p] = (p == 1) ? g1 : 10'd300;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_score;
    int run_hits;
    int phys_n;
    int ovr_n;
    exp_t e;

    Reset_n = 1'b0;
    bus.Start = 1'b0;
    bus.Ack = 1'b0;
    bus.Frame_Tick = 1'b0;
    bus.Bird_Y = 10'd200;
    set_pipes({10'd600, 10'd600, 10'd600, 10'd600}, 10'd300);
    step();
    step();

    // Reset state
    check("rst_q_initial", {31'd0, bus.q_Initial}, 32'd1);
    check("rst_q_play", {31'd0, bus.q_Play}, 32'd0);
    check("rst_q_lose", {31'd0, bus.q_Lose}, 32'd0);
    check("rst_score", {16'd0, bus.Score_BCD}, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_pipe_index", {30'd0, bus.Pipe_Index}, 32'd0);
    check("rst_phys", {31'd0, bus.Phys_Step}, 32'd0);
    Reset_n = 1'b1;
    step();

    // Frame_Tick ignored in INIT
    bus.Frame_Tick = 1'b1;
    step();
    bus.Frame_Tick = 1'b0;
    check("init_ignores_tick", {bus.q_Initial, bus.Busy}, 32'd2);

    // Start pulse, then frame timing
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check("start_to_play", {31'd0, bus.q_Play}, 32'd1);
    bus.Frame_Tick = 1'b1;
    step();
    bus.Frame_Tick = 1'b0;
    check("phys_at_1", {31'd0, bus.Phys_Step}, 32'd1);
    step();
    check("scroll_at_2", {bus.Scroll_Step, bus.Phys_Step}, 32'd2);
    for (int k = 3; k <= 8; k++) step();
    check("busy_at_8", {31'd0, bus.Busy}, 32'd1);
    step();
    check("idle_at_9", {31'd0, bus.Busy}, 32'd0);
    check("still_play", {31'd0, bus.q_Play}, 32'd1);

    // Table-driven frames with scoreboard
    vecs[0] = mk(100, 600, 600, 600, 300, 200, 1, 1'b0);
    vecs[1] = mk(100, 600, 600, 600, 300, 200, 0, 1'b0);
    vecs[2] = mk(600, 100, 100, 600, 300, 200, 2, 1'b0);
    vecs[3] = mk(100, 600, 600, 600, 300, 200, 1, 1'b0);
    vecs[4] = mk(600, 600, 600, 600, 300, 463, 0, 1'b0);
    vecs[5] = mk(600, 190, 600, 600, 150, 200, 0, 1'b0);
    vecs[6] = mk(600, 190, 600, 600, 300, 200, 0, 1'b1);
    vecs[7] = mk(600, 600, 600, 600, 300, 464, 0, 1'b1);
    vecs[8] = mk(600, 190, 600, 600,  90, 200, 0, 1'b1);
    vecs[9] = mk(600, 100, 600, 600, 300, 200, 1, 1'b0);
    run_score = 0;
    run_hits  = 0;
    for (int i = 0; i < 10; i++) begin
      set_pipes(vecs[i].x, vecs[i].g1);
      bus.Bird_Y = vecs[i].y;
      run_score += vecs[i].passes;
      run_hits  += int'(vecs[i].hit);
      e.score = 16'(run_score);
      e.lose  = vecs[i].hit && !INV;
      sb.push_back(e);
      bus.Frame_Tick = 1'b1;
      step();
      bus.Frame_Tick = 1'b0;
      wait_idle(40);
      e = sb.pop_front();
      check($sformatf("vec%0d_score", i), {16'd0, bus.Score_BCD}, {16'd0, e.score});
      check($sformatf("vec%0d_lose", i), {31'd0, bus.q_Lose}, {31'd0, e.lose});
      check($sformatf("vec%0d_play", i), {31'd0, bus.q_Play}, {31'd0, !e.lose});
`ifdef INVINCIBLE_EN
      check($sformatf("vec%0d_hit_cnt", i), {24'd0, bus.Hit_Cnt}, 32'(run_hits));
`endif
      if (e.lose) begin
        // Start and Ack together in LOSE: only Ack acts
        bus.Ack = 1'b1;
        bus.Start = 1'b1;
        step();
        bus.Ack = 1'b0;
        check($sformatf("vec%0d_ack_init", i), {bus.q_Initial, bus.q_Play}, 32'd2);
        check($sformatf("vec%0d_score_held", i), {16'd0, bus.Score_BCD}, {16'd0, e.score});
        step();
        bus.Start = 1'b0;
        check($sformatf("vec%0d_restart", i), {31'd0, bus.q_Play}, 32'd1);
        check($sformatf("vec%0d_score_clr", i), {16'd0, bus.Score_BCD}, 32'd0);
        run_score = 0;
      end
    end

    // Three ticks within one busy frame: one pending frame, one overrun
    set_pipes({10'd600, 10'd600, 10'd600, 10'd600}, 10'd300);
    bus.Bird_Y = 10'd200;
    phys_n = 0;
    ovr_n  = 0;
    for (int c = 0; c < 30; c++) begin
      bus.Frame_Tick = (c == 0) || (c == 2) || (c == 4);
      step();
      phys_n += int'(bus.Phys_Step);
      ovr_n  += int'(bus.Overrun);
    end
    bus.Frame_Tick = 1'b0;
    check("ovr_frames", 32'(phys_n), 32'd2);
    check("ovr_pulses", 32'(ovr_n), 32'd1);
    check("ovr_idle", {31'd0, bus.Busy}, 32'd0);

    // Saturation: alternate all-pass / all-clear frames back to back
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    sat_mode = 1'b1;
    bus.Frame_Tick = 1'b1;
    phys_n = 0;
    for (int c = 0; c < 50000 && phys_n < 5003; c++) begin
      step();
      if (bus.Phys_Step) begin
        phys_n++;
        if (phys_n == 7)    check("sat_bcd_carry", {16'd0, bus.Score_BCD}, 32'h0012);
        if (phys_n == 4999) check("sat_9996", {16'd0, bus.Score_BCD}, 32'h9996);
        if (phys_n == 5001) check("sat_9999", {16'd0, bus.Score_BCD}, 32'h9999);
        if (phys_n == 5003) check("sat_hold", {16'd0, bus.Score_BCD}, 32'h9999);
      end
    end
    check("sat_frames", 32'(phys_n), 32'd5003);
    bus.Frame_Tick = 1'b0;
    wait_idle(40);
    sat_mode = 1'b0;
    step();

    // Reset asserted mid-SCAN
    bus.Frame_Tick = 1'b1;
    step();
    bus.Frame_Tick = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("pre_reset_busy", {31'd0, bus.Busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("midrst_q_initial", {31'd0, bus.q_Initial}, 32'd1);
    check("midrst_score", {16'd0, bus.Score_BCD}, 32'd0);
    check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    step();
    check("midrst_hold", {bus.q_Initial, bus.Busy}, 32'd2);
    Reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
